bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//   Read-side counterpart of the acquisition write-enable logic. Once a capture
//   has landed in the BRAM, a start_read pulse makes this block sweep the whole
//   BRAM (2^BRAM_WIDTH words) from start_addr, wrapping modulo the depth.
//   Words are streamed on an AXI4-Stream master with full backpressure.
//   Sits between the BRAM read port and the DMA/FIFO path to the PS.
// PARAMETERS
//   BRAM_WIDTH       13  address width; one sweep = 2^BRAM_WIDTH words
//   BRAM_DATA_WIDTH  32  BRAM word / tdata width
//   READ_LATENCY      2  cycles from bram_en+bram_addr to valid bram_rddata; legal 1 or 2
// PORTS
//   clk            in   1                clock, all logic on rising edge
//   resetn         in   1                asynchronous active-low reset
//   start_read     in   1                1-cycle pulse, starts a sweep when idle
//   start_addr     in   BRAM_WIDTH       first address of the sweep, sampled with start_read
//   bram_addr      out  BRAM_WIDTH       BRAM read address
//   bram_en        out  1                BRAM read enable, one read per high cycle
//   bram_rddata    in   BRAM_DATA_WIDTH  BRAM read data, READ_LATENCY after bram_en
//   m_axis_tdata   out  BRAM_DATA_WIDTH  stream data
//   m_axis_tvalid  out  1                stream valid
//   m_axis_tready  in   1                stream ready
//   m_axis_tlast   out  1                high on final beat of the sweep
//   busy           out  1                high while state != IDLE
//   done           out  1                1-cycle pulse, sweep fully delivered
// BEHAVIOUR
//   - Reset (async on resetn low, effective immediately): state=IDLE, all outputs 0,
//     internal FIFO emptied, in-flight reads discarded. Reads still returning after
//     resetn deasserts are ignored.
//   - FSM IDLE -> READ -> DRAIN -> IDLE.
//     IDLE: start_read=1 latches start_addr, clears issue/beat counters, goes to READ.
//     READ: issues reads at addr = start_addr + n (mod 2^BRAM_WIDTH), n = 0..2^BRAM_WIDTH-1.
//       Goes to DRAIN in the cycle the last read is issued.
//     DRAIN: no reads. Waits for the last beat handshake, then returns to IDLE.
//       done=1 in the cycle after that handshake, coinciding with the first IDLE cycle.
//   - start_read is ignored outside IDLE; no queuing.
//   - Buffering: internal FIFO, FIFO_DEPTH = READ_LATENCY+2 (localparam).
//     A read issues in a cycle only if in_flight + fifo_count - pop < FIFO_DEPTH
//     (pop = tvalid & tready this cycle). The FIFO never overflows and returning
//     data is never dropped.
//   - Latency: start_read at cycle 0 -> bram_en=1, bram_addr=start_addr at cycle 1
//     -> data captured at cycle 1+READ_LATENCY -> first tvalid at cycle 2+READ_LATENCY.
//   - Throughput: with tready held 1, one beat/cycle. All 2^BRAM_WIDTH beats are
//     contiguous, with no bubbles.
//   - AXIS rules: tdata and tlast are stable while tvalid & !tready. tvalid never
//     drops without a handshake. tlast=1 only on beat index 2^BRAM_WIDTH-1.
//   - Counters are BRAM_WIDTH+1 bits wide so a full sweep is counted without alias.
//     bram_addr wraps from 2^BRAM_WIDTH-1 to 0.
// TESTING
//   (sim: BRAM_WIDTH=4, BRAM model data = 3*addr+1)
//   1. READ_LATENCY=2, start_addr=0, tready=1 -> 16 contiguous beats 1,4,...,46.
//      First tvalid at cycle 4, tlast on the 16th beat, done 1 cycle later, busy low then.
//   2. start_addr=13 -> addresses 13,14,15,0..12, data 40,43,46,1,...,37.
//      tlast on the data=37 beat.
//   3. tready random 50%, plus tready=0 for 10 cycles -> exactly 16 beats, in order,
//      no loss or duplicates. Reads issued but not yet popped never exceed 4.
//      tdata stable while stalled.
//   4. start_read pulsed again during beats 3 and 15 -> ignored.
//      Exactly 16 beats and one done.
//   5. resetn low after 5 beats -> tvalid/bram_en/busy 0 immediately, no done.
//      New sweep after release yields a clean 16-beat sequence.
//   6. READ_LATENCY=1 repeat of scenario 1 -> identical data, first tvalid at cycle 3.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sweeps a whole BRAM from a start address after a start
// pulse and streams the words out over an AXI4-Stream master with full
// backpressure. A small FIFO absorbs the BRAM read latency. Reads are only
// issued when every outstanding word is guaranteed a FIFO slot.
module bram_stream_reader #(
  parameter int BRAM_WIDTH      = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start_read,
  input  logic [BRAM_WIDTH-1:0]      start_addr,
  output logic [BRAM_WIDTH-1:0]      bram_addr,
  output logic                       bram_en,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rddata,
  output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       done
);

  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = CNT_W + 1;
  // Index of the final word of a sweep, in the wide counter format.
  localparam logic [BRAM_WIDTH:0] LAST_IDX = {1'b0, {BRAM_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                     state;
  logic [BRAM_WIDTH-1:0]      base_addr;
  logic [BRAM_WIDTH:0]        issue_cnt;
  logic [BRAM_WIDTH:0]        beat_cnt;
  logic [READ_LATENCY-1:0]    rd_pipe;
  logic [BRAM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           fifo_count;
  logic [OCC_W-1:0]           in_flight;
  logic                       push;
  logic                       pop;
  logic                       can_issue;

  assign push          = rd_pipe[READ_LATENCY-1];
  assign m_axis_tvalid = (fifo_count != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_IDX);
  assign busy          = (state != S_IDLE);

  // Count reads issued whose data has not yet been written into the FIFO.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    in_flight = OCC_W'(bram_en);
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + OCC_W'(rd_pipe[i]);
    end
  end

  // Issue only if every outstanding word, plus this one, has a FIFO slot.
  assign can_issue = (OCC_W'(fifo_count) + in_flight) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));

  // Track which cycles carry valid BRAM read data; reset discards in-flight reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pipe <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rd_pipe[0] <= bram_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // FIFO storage: written on the cycle the BRAM data is valid.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the emptied pointers make its contents unobservable.
    if (push) begin
      fifo_mem[wr_ptr] <= bram_rddata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sweep control: issues reads, counts delivered beats and signals completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      base_addr <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      bram_addr <= '0;
      bram_en   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      bram_en <= 1'b0;
      if (pop) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_read) begin
            // The first read goes out on the very next cycle.
            base_addr <= start_addr;
            bram_addr <= start_addr;
            bram_en   <= 1'b1;
            issue_cnt <= {{BRAM_WIDTH{1'b0}}, 1'b1};
            beat_cnt  <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (can_issue) begin
            bram_addr <= base_addr + issue_cnt[BRAM_WIDTH-1:0];
            bram_en   <= 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_axis_tlast) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: two instances (READ_LATENCY 2 and 1) with
// BRAM models returning 3*addr+1. Expected beats are queued when a sweep is
// started and compared as the DUT hands them over.
module tb_bram_stream_reader;

  localparam int BW    = 4;
  localparam int DW    = 32;
  localparam int WORDS = 1 << BW;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    start_read;
  logic [BW-1:0] start_addr [2];
  logic [BW-1:0] bram_addr  [2];
  logic [1:0]    bram_en;
  logic [DW-1:0] bram_rddata[2];
  logic [DW-1:0] tdata      [2];
  logic [1:0]    tvalid;
  logic [1:0]    tready;
  logic [1:0]    tlast;
  logic [1:0]    busy;
  logic [1:0]    done;

  always #5 clk = ~clk;

  bram_stream_reader #(.BRAM_WIDTH(BW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn), .start_read(start_read[0]), .start_addr(start_addr[0]),
    .bram_addr(bram_addr[0]), .bram_en(bram_en[0]), .bram_rddata(bram_rddata[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tlast(tlast[0]), .busy(busy[0]), .done(done[0])
  );

  bram_stream_reader #(.BRAM_WIDTH(BW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .start_read(start_read[1]), .start_addr(start_addr[1]),
    .bram_addr(bram_addr[1]), .bram_en(bram_en[1]), .bram_rddata(bram_rddata[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tlast(tlast[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic logic [DW-1:0] bword(input int addr);
    return DW'(3 * (addr % WORDS) + 1);
  endfunction

  // BRAM models: latency 2 for instance 0, latency 1 for instance 1.
  logic [DW-1:0] m0_s1, m0_s2, m1_s1;
  always @(posedge clk) begin
    m0_s1 <= bword(int'(bram_addr[0]));
    m0_s2 <= m0_s1;
    m1_s1 <= bword(int'(bram_addr[1]));
  end
  assign bram_rddata[0] = m0_s2;
  assign bram_rddata[1] = m1_s1;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Monitor state for the instance under test.
  int            act = 0;
  bit            mon_en = 0;
  int            cyc = 0;
  int            issued, popped, max_out, beats, done_cnt, last_cyc;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Scoreboard side: compare each handshake with the queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t e;
      int    out;
      if (bram_en[act]) issued++;
      out = issued - popped;
      if (out > max_out) max_out = out;
      if (tvalid[act] && prev_stall) begin
        check("stall_tdata", tdata[act], prev_data);
        check("stall_tlast", 32'(tlast[act]), 32'(prev_last));
      end
      if (tvalid[act] && tready[act]) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", tdata[act], e.data);
          check("beat_last", 32'(tlast[act]), 32'(e.last));
        end
        popped++;
        beats++;
        if (tlast[act]) last_cyc = cyc;
      end
      prev_stall = tvalid[act] && !tready[act];
      prev_data  = tdata[act];
      prev_last  = tlast[act];
      if (done[act]) done_cnt++;
    end
  end

  int first_tv, done_cyc;

  // Run one sweep. mode 0: tready=1; mode 1: random tready with a 10-cycle stall.
  // abort_at >= 0 pulls resetn after that many beats. repulse re-pulses start_read.
  task automatic run_sweep(input int inst, input int addr, input int mode,
                           input int abort_at, input bit repulse);
    bit p3 = 0, p15 = 0;
    int tail = repulse ? 20 : 0;
    act = inst;
    exp_q.delete();
    issued = 0; popped = 0; max_out = 0; beats = 0; done_cnt = 0;
    last_cyc = -1; first_tv = -1; done_cyc = -1; prev_stall = 0;
    for (int n = 0; n < WORDS; n++) begin
      beat_t b;
      b.data = bword(addr + n);
      b.last = (n == WORDS - 1);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    cyc = 0;
    start_read[inst] = 1'b1;
    start_addr[inst] = BW'(addr);
    tready[inst]     = 1'b1;
    mon_en           = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      cyc = k;
      start_read[inst] = 1'b0;
      if (mode == 0) tready[inst] = 1'b1;
      else if (k >= 8 && k < 18) tready[inst] = 1'b0;
      else tready[inst] = 1'($urandom_range(0, 1));
      if (repulse && beats == 3 && !p3) begin start_read[inst] = 1'b1; p3 = 1; end
      if (repulse && beats == 15 && !p15) begin start_read[inst] = 1'b1; p15 = 1; end
      if (abort_at >= 0 && beats == abort_at) begin
        resetn = 1'b0;
        #1;
        check("abort_tvalid", 32'(tvalid[inst]), 32'd0);
        check("abort_bram_en", 32'(bram_en[inst]), 32'd0);
        check("abort_busy", 32'(busy[inst]), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk); #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_tvalid_after", 32'(tvalid[inst]), 32'd0);
        mon_en = 1'b0;
        return;
      end
      @(negedge clk); #1;
      if (k == 1) begin
        check("first_bram_en", 32'(bram_en[inst]), 32'd1);
        check("first_bram_addr", 32'(bram_addr[inst]), 32'(addr));
      end
      if (first_tv < 0 && tvalid[inst]) first_tv = k;
      if (done_cnt > 0 && done_cyc < 0) begin
        done_cyc = k;
        check("busy_at_done", 32'(busy[inst]), 32'd0);
      end
      if (done_cyc >= 0 && k >= done_cyc + tail) break;
    end
    mon_en = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("beat_count", 32'(beats), 32'(WORDS));
    check("done_count", 32'(done_cnt), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_after_tlast", 32'(done_cyc), 32'(last_cyc + 1));
  endtask

  initial begin
    resetn      = 1'b0;
    start_read  = '0;
    tready      = '0;
    start_addr[0] = '0;
    start_addr[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_tvalid", 32'(tvalid[i]), 32'd0);
      check("rst_bram_en", 32'(bram_en[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_tlast", 32'(tlast[i]), 32'd0);
    end
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // 1: latency 2, start 0, always ready.
    run_sweep(0, 0, 0, -1, 1'b0);
    check("s1_first_tvalid", 32'(first_tv), 32'd4);
    check("s1_contiguous", 32'(last_cyc), 32'(first_tv + WORDS - 1));
    check("s1_outstanding", 32'(max_out <= 4), 32'd1);

    // 2: start 13 wraps through 15 -> 0.
    run_sweep(0, 13, 0, -1, 1'b0);
    check("s2_contiguous", 32'(last_cyc), 32'(first_tv + WORDS - 1));

    // 3: random backpressure with a long stall.
    run_sweep(0, 6, 1, -1, 1'b0);
    check("s3_outstanding", 32'(max_out <= 4), 32'd1);

    // 4: start_read re-pulsed mid-sweep is ignored.
    run_sweep(0, 2, 1, -1, 1'b1);

    // 5: reset after 5 beats, then a clean sweep.
    run_sweep(0, 9, 0, 5, 1'b0);
    run_sweep(0, 0, 0, -1, 1'b0);
    check("s5_first_tvalid", 32'(first_tv), 32'd4);

    // 6: latency 1 instance.
    run_sweep(1, 0, 0, -1, 1'b0);
    check("s6_first_tvalid", 32'(first_tv), 32'd3);
    check("s6_contiguous", 32'(last_cyc), 32'(first_tv + WORDS - 1));
    check("s6_outstanding", 32'(max_out <= 3), 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
